// File: rtl/alu_op_responder_if.sv
// ---------------------------------------------------------------------------
// alu_op_responder_if
// Bundles every bus signal around the ALU responder: the requester side
// (one-hot start strobes, operands, per-operation results and ready pulses),
// the shared floating-point core side (start/op/operands out, result/valid
// back) and the status side (busy, sticky error, error clear).
//
// Modports:
//   slave  - the responder (alu_op_responder)
//   master - whatever drives requests and models the core (requester/bench)
// ---------------------------------------------------------------------------
interface alu_op_responder_if #(
    parameter int DATA_WIDTH = 32
);
    // Requester side
    logic                  mult_start;
    logic                  add_start;
    logic                  divide_start;
    logic                  exponent_start;
    logic [DATA_WIDTH-1:0] operand_a;
    logic [DATA_WIDTH-1:0] operand_b;
    logic [DATA_WIDTH-1:0] mult_result;
    logic [DATA_WIDTH-1:0] add_result;
    logic [DATA_WIDTH-1:0] divide_result;
    logic [DATA_WIDTH-1:0] exponent_result;
    logic                  mult_data_ready;
    logic                  add_data_ready;
    logic                  divide_data_ready;
    logic                  exponent_data_ready;

    // Shared floating-point core side
    logic                  core_start;
    logic [1:0]            core_op;
    logic [DATA_WIDTH-1:0] core_a;
    logic [DATA_WIDTH-1:0] core_b;
    logic [DATA_WIDTH-1:0] core_result;
    logic                  core_valid;

    // Status
    logic                  busy;
    logic                  err_clear;
    logic                  error;
    logic [1:0]            error_code;

    modport slave (
        input  mult_start, add_start, divide_start, exponent_start,
        input  operand_a, operand_b,
        output mult_result, add_result, divide_result, exponent_result,
        output mult_data_ready, add_data_ready, divide_data_ready, exponent_data_ready,
        output core_start, core_op, core_a, core_b,
        input  core_result, core_valid,
        output busy,
        input  err_clear,
        output error, error_code
    );

    modport master (
        output mult_start, add_start, divide_start, exponent_start,
        output operand_a, operand_b,
        input  mult_result, add_result, divide_result, exponent_result,
        input  mult_data_ready, add_data_ready, divide_data_ready, exponent_data_ready,
        input  core_start, core_op, core_a, core_b,
        output core_result, core_valid,
        input  busy,
        output err_clear,
        input  error, error_code
    );
endinterface

// File: rtl/alu_op_responder.sv
// ---------------------------------------------------------------------------
// alu_op_responder
// Responder end of the ALU request interface. Accepts one-hot start strobes,
// serialises each request onto one shared floating-point core through a
// start/valid handshake and returns the result with a one-cycle data_ready
// pulse on the matching operation. Idle result buses are always zero so the
// requester can OR them together. A core that never answers is cut off after
// TIMEOUT_CYCLES wait cycles with a quiet NaN result.
//
// Ports:
//   clock - rising-edge system clock
//   reset - asynchronous, active-high reset
//   bus   - alu_op_responder_if.slave (requests, results, core handshake,
//           busy / error / error_code / err_clear)
//
// core_op encoding (also the internal op index): 0 exponent, 1 mult,
// 2 divide, 3 add. error_code: 01 multi-strobe, 10 timeout, 11 strobe busy.
// ---------------------------------------------------------------------------
module alu_op_responder #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int EXP_LEN        = 8,
    parameter int MANTISSA_LEN   = 23
) (
    input  logic               clock,
    input  logic               reset,
    alu_op_responder_if.slave  bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Quiet NaN: sign 0, exponent all ones, mantissa MSB set.
    localparam logic [DATA_WIDTH-1:0] QNAN =
        DATA_WIDTH'({1'b0, {EXP_LEN{1'b1}}, 1'b1, {(MANTISSA_LEN-1){1'b0}}});

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    state_t                state_reg, state_next;
    logic [1:0]            op_reg;
    logic [DATA_WIDTH-1:0] a_reg, b_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic                  core_start_reg;
    logic                  error_reg;
    logic [1:0]            code_reg;
    logic [3:0]            ready_reg;
    logic [DATA_WIDTH-1:0] result_reg [4];

    // Strobes ordered by op index: {add, divide, mult, exponent}.
    logic [3:0] strobes;
    logic       any_strobe, multi_strobe;
    logic [1:0] sel_op;
    logic       timeout_hit, wait_done;
    logic [DATA_WIDTH-1:0] resp_value;
    logic       err_set;
    logic [1:0] err_code_new;

    assign strobes      = {bus.add_start, bus.divide_start, bus.mult_start, bus.exponent_start};
    assign any_strobe   = |strobes;
    // More than one bit set iff clearing the lowest set bit leaves something.
    assign multi_strobe = |(strobes & (strobes - 4'd1));
    assign timeout_hit  = (cnt_reg == CNT_W'(TIMEOUT_CYCLES));
    assign wait_done    = (state_reg == WAIT) && (bus.core_valid || timeout_hit);
    // A valid in the timeout cycle wins over the forced NaN.
    assign resp_value   = bus.core_valid ? bus.core_result : QNAN;

    // Fixed priority add > divide > mult > exponent.
    always_comb begin
        sel_op = 2'd0;
        if (strobes[3])      sel_op = 2'd3;
        else if (strobes[2]) sel_op = 2'd2;
        else if (strobes[1]) sel_op = 2'd1;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_strobe) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (wait_done) state_next = RESPOND;
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Error detection; a timeout outranks a busy strobe in the same cycle
    // because it describes the request actually being served.
    always_comb begin
        err_set      = 1'b0;
        err_code_new = 2'b00;
        if (state_reg == IDLE && multi_strobe) begin
            err_set      = 1'b1;
            err_code_new = 2'b01;
        end
        if (state_reg != IDLE && any_strobe) begin
            err_set      = 1'b1;
            err_code_new = 2'b11;
        end
        if (state_reg == WAIT && !bus.core_valid && timeout_hit) begin
            err_set      = 1'b1;
            err_code_new = 2'b10;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            op_reg         <= 2'd0;
            a_reg          <= '0;
            b_reg          <= '0;
            cnt_reg        <= '0;
            core_start_reg <= 1'b0;
            error_reg      <= 1'b0;
            code_reg       <= 2'b00;
        end else begin
            state_reg      <= state_next;
            core_start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (any_strobe) begin
                        op_reg         <= sel_op;
                        a_reg          <= bus.operand_a;
                        b_reg          <= bus.operand_b;
                        core_start_reg <= 1'b1;
                    end
                end
                ISSUE: cnt_reg <= CNT_W'(1);
                WAIT:  if (!wait_done) cnt_reg <= cnt_reg + 1'b1;
                default: ;
            endcase
            // A new error in the same cycle as err_clear takes precedence.
            if (err_set) begin
                error_reg <= 1'b1;
                code_reg  <= err_code_new;
            end else if (bus.err_clear) begin
                error_reg <= 1'b0;
                code_reg  <= 2'b00;
            end
        end
    end

    // Per-operation result/ready registers: loaded only for the served op in
    // the cycle that enters RESPOND, zero otherwise (OR-combinable buses).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_resp
            logic hit;
            assign hit = wait_done && (op_reg == 2'(gi));
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    ready_reg[gi]  <= 1'b0;
                    result_reg[gi] <= '0;
                end else begin
                    ready_reg[gi]  <= hit;
                    result_reg[gi] <= hit ? resp_value : '0;
                end
            end
        end
    endgenerate

    assign bus.exponent_result     = result_reg[0];
    assign bus.mult_result         = result_reg[1];
    assign bus.divide_result       = result_reg[2];
    assign bus.add_result          = result_reg[3];
    assign bus.exponent_data_ready = ready_reg[0];
    assign bus.mult_data_ready     = ready_reg[1];
    assign bus.divide_data_ready   = ready_reg[2];
    assign bus.add_data_ready      = ready_reg[3];

    assign bus.core_start = core_start_reg;
    assign bus.core_op    = op_reg;
    assign bus.core_a     = a_reg;
    assign bus.core_b     = b_reg;
    assign bus.busy       = (state_reg != IDLE);
    assign bus.error      = error_reg;
    assign bus.error_code = code_reg;
endmodule

// File: tb/tb_alu_op_responder.sv
// ---------------------------------------------------------------------------
// tb_alu_op_responder
// Table-driven directed bench for alu_op_responder with TIMEOUT_CYCLES=8.
// Each table record is one request; a shared task applies it, models the
// core response and checks handshake timing, result buses, readies and the
// error state. Hand-written sequences cover the late core_valid in IDLE and
// the reset abort during WAIT.
// ---------------------------------------------------------------------------
module tb_alu_op_responder;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    alu_op_responder_if #(.DATA_WIDTH(DW)) bus ();

    alu_op_responder #(
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TMO),
        .EXP_LEN       (8),
        .MANTISSA_LEN  (23)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // strobes/inj ordered {add, divide, mult, exponent}; k = cycles after the
    // ISSUE cycle at which core_valid arrives (0 = never, forces timeout).
    typedef struct {
        logic [3:0]  strobes;
        logic [31:0] a;
        logic [31:0] b;
        int          k;
        logic [31:0] val;
        logic [1:0]  op;
        logic        err;
        logic [1:0]  code;
        logic        clear;
        logic        clr_same;
        int          inj_cyc;
        logic [3:0]  inj;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [127:0] all_results();
        return {bus.add_result, bus.divide_result, bus.mult_result, bus.exponent_result};
    endfunction

    function automatic logic [3:0] all_readies();
        return {bus.add_data_ready, bus.divide_data_ready, bus.mult_data_ready, bus.exponent_data_ready};
    endfunction

    task automatic set_strobes(input logic [3:0] s);
        bus.add_start      = s[3];
        bus.divide_start   = s[2];
        bus.mult_start     = s[1];
        bus.exponent_start = s[0];
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_quiet(input string name);
        chk({name, "_ready"}, 128'(all_readies()), 128'(0));
        chk({name, "_results"}, all_results(), 128'(0));
        chk({name, "_start_busy"}, 128'({bus.core_start, bus.busy}), 128'(0));
    endtask

    // Called in an IDLE slot (1 time unit after a rising edge); returns in
    // the IDLE slot right after RESPOND, so consecutive calls are back-to-back.
    task automatic run_vec(input int idx, input vec_t v);
        int ready_cyc;
        logic [127:0] exp_res;
        if (v.clear) begin
            bus.err_clear = 1'b1;
            step();
            bus.err_clear = 1'b0;
            chk("pre_clear", 128'({bus.error, bus.error_code}), 128'(0));
        end
        // Slot T
        chk("idle_busy", 128'(bus.busy), 128'(0));
        set_strobes(v.strobes);
        bus.operand_a = v.a;
        bus.operand_b = v.b;
        bus.err_clear = v.clr_same;
        step();
        // Slot T+1: ISSUE
        set_strobes(4'b0000);
        bus.operand_a = 32'h0;
        bus.operand_b = 32'h0;
        bus.err_clear = 1'b0;
        chk("issue_start", 128'({bus.core_start, bus.busy}), 128'(2'b11));
        chk("issue_op_ops", 128'({bus.core_op, bus.core_a, bus.core_b}), 128'({v.op, v.a, v.b}));
        ready_cyc = (v.k > 0) ? v.k + 1 : TMO + 1;
        exp_res = '0;
        exp_res[int'(v.op)*32 +: 32] = v.val;
        for (int cyc = 1; cyc <= ready_cyc; cyc++) begin
            step();
            bus.core_valid  = 1'b0;
            bus.core_result = 32'h0;
            if (cyc < ready_cyc) begin
                chk("wait_ready", 128'(all_readies()), 128'(0));
                chk("wait_results", all_results(), 128'(0));
                chk("wait_start_busy", 128'({bus.core_start, bus.busy}), 128'(2'b01));
                chk("wait_stable", 128'({bus.core_op, bus.core_a, bus.core_b}), 128'({v.op, v.a, v.b}));
            end else begin
                chk("resp_ready", 128'(all_readies()), 128'(4'b0001 << v.op));
                chk("resp_results", all_results(), exp_res);
                chk("resp_busy", 128'(bus.busy), 128'(1));
                chk("resp_error", 128'({bus.error, bus.error_code}), 128'({v.err, v.code}));
            end
            if (cyc == v.k) begin
                bus.core_valid  = 1'b1;
                bus.core_result = v.val;
            end
            if (v.inj_cyc != 0) begin
                if (cyc == v.inj_cyc) set_strobes(v.inj);
                if (cyc == v.inj_cyc + 1) begin
                    set_strobes(4'b0000);
                    chk("busy_strobe_err", 128'({bus.error, bus.error_code}), 128'(3'b111));
                    bus.err_clear = 1'b1;
                end
                if (cyc == v.inj_cyc + 2) begin
                    bus.err_clear = 1'b0;
                    chk("err_cleared", 128'({bus.error, bus.error_code}), 128'(0));
                end
            end
        end
        step();
        check_quiet("post_idle");
        $display("txn %0d: strobes=%b op=%0d result=%08h ready_cycle=T+%0d error=%b code=%b",
                 idx, v.strobes, v.op, v.val, ready_cyc + 1, v.err, v.code);
    endtask

    initial begin
        vecs[0]  = '{4'b0010, 32'h40000000, 32'h40400000, 3, 32'h40C00000, 2'd1, 1'b0, 2'd0, 1'b1, 1'b0, 0, 4'b0000};
        vecs[1]  = '{4'b1000, 32'h3F800000, 32'h3F800000, 1, 32'h40000000, 2'd3, 1'b0, 2'd0, 1'b1, 1'b0, 0, 4'b0000};
        vecs[2]  = '{4'b0100, 32'h40C00000, 32'h40000000, 2, 32'h40400000, 2'd2, 1'b0, 2'd0, 1'b1, 1'b0, 0, 4'b0000};
        vecs[3]  = '{4'b0001, 32'h3F800000, 32'h00000000, 5, 32'h402DF854, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 0, 4'b0000};
        vecs[4]  = '{4'b0100, 32'h41200000, 32'h40000000, 1, 32'h40A00000, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 0, 4'b0000};
        vecs[5]  = '{4'b1000, 32'h3F800000, 32'h40000000, 0, 32'h7FC00000, 2'd3, 1'b1, 2'd2, 1'b1, 1'b0, 0, 4'b0000};
        vecs[6]  = '{4'b1010, 32'h40400000, 32'h40000000, 2, 32'h40A00000, 2'd3, 1'b1, 2'd1, 1'b1, 1'b0, 0, 4'b0000};
        vecs[7]  = '{4'b1111, 32'h11111111, 32'h22222222, 1, 32'h12345678, 2'd3, 1'b1, 2'd1, 1'b1, 1'b1, 0, 4'b0000};
        vecs[8]  = '{4'b0111, 32'h33333333, 32'h44444444, 3, 32'h0BADF00D, 2'd2, 1'b1, 2'd1, 1'b1, 1'b0, 0, 4'b0000};
        vecs[9]  = '{4'b0011, 32'h3E800000, 32'h3E000000, 1, 32'h3C000000, 2'd1, 1'b1, 2'd1, 1'b1, 1'b0, 0, 4'b0000};
        vecs[10] = '{4'b0001, 32'h3F800000, 32'h00000000, 8, 32'h40490FDB, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 0, 4'b0000};
        vecs[11] = '{4'b0010, 32'h40800000, 32'h40000000, 5, 32'h41000000, 2'd1, 1'b0, 2'd0, 1'b1, 1'b0, 2, 4'b0100};

        reset           = 1'b1;
        set_strobes(4'b0000);
        bus.operand_a   = 32'h0;
        bus.operand_b   = 32'h0;
        bus.core_result = 32'h0;
        bus.core_valid  = 1'b0;
        bus.err_clear   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_quiet("reset");
        chk("reset_core_err", 128'({bus.core_op, bus.core_a, bus.core_b, bus.error, bus.error_code}), 128'(0));
        reset = 1'b0;
        step();

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Timeout again, then a late core_valid in IDLE must do nothing.
        run_vec(5, vecs[5]);
        bus.core_valid  = 1'b1;
        bus.core_result = 32'hDEADBEEF;
        bus.err_clear   = 1'b1;
        step();
        bus.core_valid  = 1'b0;
        bus.core_result = 32'h0;
        bus.err_clear   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_quiet("late_valid");
            chk("late_valid_err", 128'({bus.error, bus.error_code}), 128'(0));
            step();
        end
        $display("txn late_valid: core_valid in IDLE ignored");

        // Reset asserted during WAIT aborts the request.
        set_strobes(4'b0010);
        bus.operand_a = 32'h40000000;
        bus.operand_b = 32'h40400000;
        step();
        set_strobes(4'b0000);
        step();
        step();
        chk("abort_pre_busy", 128'(bus.busy), 128'(1));
        reset = 1'b1;
        #1;
        check_quiet("abort_reset");
        chk("abort_core_err", 128'({bus.core_op, bus.core_a, bus.core_b, bus.error, bus.error_code}), 128'(0));
        step();
        reset           = 1'b0;
        bus.core_valid  = 1'b1;
        bus.core_result = 32'h40C00000;
        step();
        bus.core_valid  = 1'b0;
        bus.core_result = 32'h0;
        for (int i = 0; i < 4; i++) begin
            check_quiet("abort_after");
            step();
        end
        $display("txn reset_abort: no ready after reset during WAIT");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/alu_op_responder.md
Name: alu_op_responder

Overview:
- Responder end of the ALU request interface driven by the term accumulator: accepts one-hot start strobes with operand_a/operand_b and returns a result with a per-operation data_ready pulse.
- Serialises all requests onto one shared floating-point core through a start/valid handshake.
- Guarantees the OR-combining requirement of the requester: every idle result bus and data_ready is zero, including on timeout.
- Adds protocol error detection (multiple strobes, strobe while busy, core timeout).

Parameters:
DATA_WIDTH, 32, operand/result width (IEEE-754 layout, EXP_LEN=8, MANTISSA_LEN=23 when 32)
TIMEOUT_CYCLES, 1023, maximum WAIT cycles before forced response; must be >=1
EXP_LEN, 8, exponent field width, used to build the timeout NaN
MANTISSA_LEN, 23, mantissa field width, used to build the timeout NaN

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
mult_start / add_start / divide_start / exponent_start  in  1 each  single-cycle request strobes
operand_a  in  DATA_WIDTH  first operand, valid in the strobe cycle
operand_b  in  DATA_WIDTH  second operand, valid in the strobe cycle
mult_result / add_result / divide_result / exponent_result  out  DATA_WIDTH each  result buses, zero unless the matching ready is high
mult_data_ready / add_data_ready / divide_data_ready / exponent_data_ready  out  1 each  one-cycle completion pulses
core_start  out  1  one-cycle request to the shared FP core
core_op  out  2  00 exponent, 01 mult, 10 divide, 11 add
core_a, core_b  out  DATA_WIDTH  latched operands to the core
core_result  in  DATA_WIDTH  core output, valid with core_valid
core_valid  in  1  core completion pulse
busy  out  1  high in every state except IDLE
err_clear  in  1  synchronous clear of error and error_code
error  out  1  sticky error flag
error_code  out  2  last error: 01 multi-strobe, 10 timeout, 11 strobe while busy

Behaviour:
- Reset (async assert): state=IDLE; all outputs 0, including results, readies, core_*, busy, error, error_code; timeout counter 0.
- IDLE:
  - No strobe: remain.
  - Any strobe in cycle T: latch op, operand_a, operand_b; go to ISSUE.
  - More than one strobe: serve by priority add > divide > mult > exponent; set error=1, error_code=01.
- ISSUE (T+1): core_start=1 for exactly this cycle; core_op/core_a/core_b are driven from the latches and held stable until leaving WAIT; counter=1; go to WAIT. core_valid is ignored in ISSUE.
- WAIT:
  - core_valid: latch core_result; go to RESPOND.
  - Else, counter==TIMEOUT_CYCLES: latch quiet NaN (sign 0, exponent all ones, mantissa MSB 1, rest 0; 0x7FC00000 at defaults); set error=1, error_code=10; go to RESPOND.
  - Else: counter+1.
  - core_valid in the same cycle as the timeout condition: valid wins, no error.
- RESPOND: drive the selected data_ready=1 and the selected result=latched value for exactly one cycle; all other result buses are 0; go to IDLE.
  - Latency: strobe at T, core_valid at T+1+k (k>=1), ready at T+2+k. The next strobe is accepted from the cycle after RESPOND.
- Any strobe seen in ISSUE/WAIT/RESPOND: ignored; no state change; error=1, error_code=11.
- Late core_valid in IDLE (e.g. after timeout): ignored; no error.
- Errors:
  - Sticky; a new error overwrites error_code.
  - err_clear zeroes error and error_code. If err_clear and a new error occur in the same cycle, the new error wins.
- Reset mid-operation: immediate abort. No ready or core_start is emitted for the aborted request.
- Outputs are registered; no combinational path from strobes to readies.

Test Plan:
- Single mult: mult_start at T with a=0x40000000, b=0x40400000; core_valid at T+4 with 0x40C00000 -> core_start at T+1 with op=01; mult_data_ready and mult_result=0x40C00000 at T+5 only; other results 0; busy T+1..T+5.
- Timeout with TIMEOUT_CYCLES=8: add_start, core never valid -> add_data_ready at T+10 with add_result=0x7FC00000; error=1, error_code=10. A later core_valid in IDLE is ignored.
- Multi-strobe: add_start and mult_start together -> core_op=11; only add_data_ready pulses; error_code=01.
- Strobe while busy: divide_start during WAIT -> no effect on the current op; error_code=11. err_clear the next cycle -> error=0.
- Back-to-back: exponent request, then divide_start in the cycle after RESPOND -> accepted. Both complete with correct ready pulses; result buses are never simultaneously nonzero.
- Reset asserted during WAIT -> all outputs 0 immediately; core_valid after deassert produces no ready.
